rx_bit_timer: RTL and testbench
===============================

# rx_bit_timer

Receive-side bit-timing block for the CDL serial link. It waits for the first line transition, then produces a one-cycle sample strobe at a fixed point inside every bit period and a one-cycle flag after each full byte. Each detected edge re-aligns the bit period. It sits between the RX edge detector and the RX shift register and RCU, and is the receive counterpart of the transmit bit timer.

## Interface
- CLKS_PER_BIT, 8, clock cycles per bit period; legal range 4..63.
- SAMPLE_POINT, 3, value of the internal cycle counter at which a bit is sampled; legal range 1..CLKS_PER_BIT-1.
- clk  in  1  system clock; all state updates on the rising edge.
- n_rst  in  1  reset, synchronous and active-low.
- enable_timer  in  1  RCU request to time a packet; low forces the block idle.
- d_edge  in  1  one-cycle pulse from the edge detector marking a line transition.
- shift_enable  out  1  one-cycle sample strobe to the RX shift register.
- byte_received  out  1  one-cycle pulse after the 8th shift_enable of a byte.
- bit_count  out  3  number of bits already shifted in the current byte (0..7).
- synced  out  1  high while in RUN.

## Operation
- Internal state:
  - FSM with states IDLE, WAIT_EDGE and RUN.
  - clk_cnt, width $clog2(CLKS_PER_BIT).
  - bit_cnt, 3 bits, drives bit_count.
  - byte_received register.
- FSM transitions:
  - IDLE -> WAIT_EDGE when enable_timer=1.
  - WAIT_EDGE -> RUN when d_edge=1 (and enable_timer=1).
  - In any state, enable_timer=0 -> IDLE next cycle. This clears clk_cnt, bit_cnt and byte_received.
- clk_cnt update:
  - Held at 0 in IDLE and WAIT_EDGE.
  - In RUN or on the WAIT_EDGE->RUN transition:
    - next = 1 if d_edge;
    - else 0 if clk_cnt == CLKS_PER_BIT-1;
    - else clk_cnt+1.
  - The edge cycle is therefore bit-cycle 0.
- shift_enable is decoded from registers (Moore): high iff state==RUN and clk_cnt==SAMPLE_POINT.
- bit_cnt update on a cycle where shift_enable=1:
  - if bit_cnt==7: bit_cnt <= 0 and byte_received <= 1;
  - else bit_cnt <= bit_cnt+1.
  - byte_received is 0 on every other cycle.
- synced = (state==RUN).
- Simultaneous events:
  - d_edge while shift_enable=1: the strobe is still issued and counted. The resync sets clk_cnt=1 next cycle.
  - d_edge in RUN at any clk_cnt: the block resynchronises; no bit is added or dropped by the block itself.
  - enable_timer=0 overrides d_edge and any pending count.

## Timing
- Reset values (n_rst=0 at a rising edge, any state):
  - FSM = IDLE.
  - shift_enable, byte_received, bit_count, synced all 0 from the following cycle.
- Reset mid-operation discards any partial byte. After reset release the block restarts from IDLE.
- Edge-to-sample latency with no further edges: the first shift_enable comes SAMPLE_POINT cycles after the d_edge cycle. Later strobes come every CLKS_PER_BIT cycles.
- byte_received rises the cycle after the 8th shift_enable. In that same cycle bit_count reads 0.
- The counter wraps at CLKS_PER_BIT-1 and produces no strobe at the wrap. bit_cnt wraps 7->0 with no overflow state.
- No outputs depend combinationally on inputs.

## Test plan
- Reset and idle:
  - Stimulus: n_rst=0 for 2 cycles, then enable_timer=0 and random d_edge.
  - Required: all outputs 0 throughout; synced stays 0.
- Basic byte, defaults:
  - Stimulus: enable_timer=1 at cycle 0, d_edge at cycle 5 only.
  - Required: synced=1 from cycle 6; shift_enable at cycles 8, 16, ..., 64; byte_received only at cycle 65; bit_count steps 0..7 and reads 0 at 65.
- Resync:
  - Stimulus: same as the basic byte case, plus a d_edge at cycle 13.
  - Required: strobe at 8, next strobe at 16 (edge at 13 gives 13+3), then 24.
  - Stimulus: move the extra d_edge to cycle 11.
  - Required: next strobe at 14.
- Edge coincident with a strobe:
  - Stimulus: d_edge at cycle 8 in the basic byte setup.
  - Required: shift_enable still high at 8, bit_count=1 at 9, next strobe at 11.
- Abort:
  - Stimulus: drop enable_timer at cycle 30; separately, pulse n_rst=0 at cycle 30.
  - Required: all outputs 0 and state IDLE from cycle 31; re-enabling needs a new d_edge before any strobe.
- Parameter sweep:
  - Stimulus: CLKS_PER_BIT=4, SAMPLE_POINT=1 and CLKS_PER_BIT=16, SAMPLE_POINT=15, each with two back-to-back bytes.
  - Required: strobe spacing equals CLKS_PER_BIT; exactly two byte_received pulses, 8 strobes apart.

Source files
------------

// File: rtl/rx_bit_timer.sv
// Receive bit timer: waits for the first line edge, then strobes shift_enable at a
// fixed offset inside each bit period and flags every completed byte.
module rx_bit_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable_timer,
    input  logic       d_edge,
    output logic       shift_enable,
    output logic       byte_received,
    output logic [2:0] bit_count,
    output logic       synced
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_POINT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        RUN
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic          byte_reg, byte_next;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            byte_reg <= 1'b0;
        end else begin
            state    <= state_next;
            clk_cnt  <= clk_cnt_next;
            bit_cnt  <= bit_cnt_next;
            byte_reg <= byte_next;
        end
    end

    always_comb begin
        state_next   = state;
        clk_cnt_next = '0;
        bit_cnt_next = bit_cnt;
        byte_next    = 1'b0;

        if (!enable_timer) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
        end else begin
            case (state)
                IDLE:      state_next = WAIT_EDGE;
                WAIT_EDGE: if (d_edge) state_next = RUN;
                RUN:       state_next = RUN;
                default:   state_next = IDLE;
            endcase

            // An edge restarts the period: the edge cycle counts as bit-cycle 0.
            if (state_next == RUN) begin
                if (d_edge)
                    clk_cnt_next = CW'(1);
                else if (clk_cnt == LAST_CNT)
                    clk_cnt_next = '0;
                else
                    clk_cnt_next = clk_cnt + 1'b1;
            end

            if (shift_enable) begin
                if (bit_cnt == 3'd7) begin
                    bit_cnt_next = '0;
                    byte_next    = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt + 3'd1;
                end
            end
        end
    end

    assign shift_enable  = (state == RUN) && (clk_cnt == SAMPLE_CNT);
    assign byte_received = byte_reg;
    assign bit_count     = bit_cnt;
    assign synced        = (state == RUN);

endmodule

// File: tb/tb_rx_bit_timer.sv
// Bench for rx_bit_timer: three parameterisations share one stimulus stream and are
// checked every cycle against an edge-history model of the bit timing.
module tb_rx_bit_timer;

    localparam int HIST = 8192;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic enable_timer = 1'b0;
    logic d_edge = 1'b0;

    logic       se_d, br_d, sy_d;
    logic [2:0] bc_d;
    logic       se_f, br_f, sy_f;
    logic [2:0] bc_f;
    logic       se_s, br_s, sy_s;
    logic [2:0] bc_s;

    bit rst_h [HIST];
    bit en_h  [HIST];
    bit edge_h[HIST];
    int g = 0;

    int vectors = 0;
    int miscompares = 0;
    int bytes_f = 0;
    int bytes_s = 0;

    always #5 clk = ~clk;

    rx_bit_timer #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3)) dut_def (
        .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .d_edge(d_edge),
        .shift_enable(se_d), .byte_received(br_d), .bit_count(bc_d), .synced(sy_d)
    );

    rx_bit_timer #(.CLKS_PER_BIT(4), .SAMPLE_POINT(1)) dut_fast (
        .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .d_edge(d_edge),
        .shift_enable(se_f), .byte_received(br_f), .bit_count(bc_f), .synced(sy_f)
    );

    rx_bit_timer #(.CLKS_PER_BIT(16), .SAMPLE_POINT(15)) dut_slow (
        .clk(clk), .n_rst(n_rst), .enable_timer(enable_timer), .d_edge(d_edge),
        .shift_enable(se_s), .byte_received(br_s), .bit_count(bc_s), .synced(sy_s)
    );

    // Expected {synced, shift_enable, byte_received, bit_count} at cycle t, derived
    // from the recorded input history: the session starts after the last cycle with
    // reset or enable low, locks on the first edge seen in WAIT_EDGE, and samples
    // whenever the distance from the latest edge is SAMPLE_POINT modulo the period.
    function automatic logic [5:0] model(int c, int s, int t);
        int   k = -1;
        int   e0 = -1;
        int   last;
        int   n = 0;
        logic sh = 1'b0;
        logic br = 1'b0;
        for (int j = t - 1; j >= 0; j--)
            if (!rst_h[j] || !en_h[j]) begin
                k = j;
                break;
            end
        if (k < 0) return '0;
        for (int j = k + 2; j < t; j++)
            if (edge_h[j]) begin
                e0 = j;
                break;
            end
        if (e0 < 0) return '0;
        last = e0;
        for (int u = e0 + 1; u <= t; u++) begin
            if ((u - last) % c == s) begin
                if (u == t) sh = 1'b1;
                else begin
                    n++;
                    br = (u == t - 1) && (n % 8 == 0);
                end
            end
            if (u < t && edge_h[u]) last = u;
        end
        return {1'b1, sh, br, 3'(n % 8)};
    endfunction

    task automatic check_dut(input string tag, input int c, input int s,
                             input logic sy, input logic se, input logic br,
                             input logic [2:0] bc);
        logic [5:0] exp_v;
        logic [5:0] obs_v;
        exp_v = model(c, s, g);
        obs_v = {sy, se, br, bc};
        vectors++;
        assert (obs_v === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s cycle %0d sync/shift/byte/count observed %b expected %b",
                   tag, g, obs_v, exp_v);
        end
    endtask

    task automatic step(input bit r, input bit en, input bit d);
        rst_h[g]     = r;
        en_h[g]      = en;
        edge_h[g]    = d;
        n_rst        = r;
        enable_timer = en;
        d_edge       = d;
        @(posedge clk);
        @(negedge clk);
        g++;
        if (br_f) bytes_f++;
        if (br_s) bytes_s++;
        check_dut("cpb8_sp3", 8, 3, sy_d, se_d, br_d, bc_d);
        check_dut("cpb4_sp1", 4, 1, sy_f, se_f, br_f, bc_f);
        check_dut("cpb16_sp15", 16, 15, sy_s, se_s, br_s, bc_s);
    endtask

    // Relative cycle 0 is the first cycle with enable_timer high.
    task automatic scenario(input int len, input int e1, input int e2,
                            input int drop_at, input int rst_at);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        bytes_f = 0;
        bytes_s = 0;
        for (int c = 0; c < len; c++)
            step(c != rst_at, c != drop_at, (c == e1) || (c == e2));
    endtask

    task automatic random_run(input int len, input int edge_odds);
        for (int c = 0; c < len; c++)
            step($urandom_range(0, 199) != 0, $urandom_range(0, 59) != 0,
                 $urandom_range(0, edge_odds - 1) == 0);
    endtask

    initial begin
        @(negedge clk);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));

        scenario(80, 5, -1, -1, -1);
        scenario(40, 5, 13, -1, -1);
        scenario(40, 5, 11, -1, -1);
        scenario(40, 5, 8, -1, -1);
        scenario(70, 5, 50, 30, -1);
        scenario(70, 5, 50, -1, 30);

        scenario(75, 5, -1, -1, -1);
        vectors++;
        assert (bytes_f == 2)
        else begin
            miscompares++;
            $error("FAIL byte_pulses_cpb4 observed %0d expected 2", bytes_f);
        end

        scenario(270, 5, -1, -1, -1);
        vectors++;
        assert (bytes_s == 2)
        else begin
            miscompares++;
            $error("FAIL byte_pulses_cpb16 observed %0d expected 2", bytes_s);
        end

        random_run(1000, 12);
        random_run(800, 60);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
